inst_loader: RTL

Boot-time program loader that sits upstream of the minimal SOPC's instruction memory. It receives a byte stream (length header followed by instruction words) over a valid/ready handshake and assembles big-endian 32-bit MIPS words. It writes each word sequentially into the instruction RAM write port and holds the CPU core in reset until the whole image is written. It releases the core only after a complete, in-range image has loaded.

---
 rtl/inst_loader.sv | 118 +++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// Boot-time program loader: assembles a big-endian length header and instruction
// words from a byte stream, writes them to instruction RAM, then releases the core.
module inst_loader #(
   parameter int unsigned ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        byte_i,
   input  logic              byte_valid_i,
   output logic              byte_ready_o,
   output logic              we_o,
   output logic [ADDR_W-1:0] waddr_o,
   output logic [31:0]       wdata_o,
   output logic              cpu_rst_o,
   output logic              done_o,
   output logic              err_o,
   output logic [ADDR_W:0]   words_loaded_o
);

   localparam logic [32:0] CAPACITY = 33'(1) << ADDR_W;

   typedef enum logic [2:0] {
      HDR,
      DATA,
      WRITE,
      DONE,
      ERR
   } state_t;

   state_t state, state_next;

   logic [1:0]      byte_cnt;
   logic [23:0]     shift;
   logic [31:0]     len;
   logic [31:0]     word;
   logic            accept;
   logic            word_full;
   logic [ADDR_W:0] count_inc;

   assign accept    = byte_valid_i & byte_ready_o;
   assign word      = {shift, byte_i};
   assign word_full = accept && (byte_cnt == 2'd3);
   assign count_inc = words_loaded_o + (ADDR_W+1)'(1);

   always_comb begin
      state_next   = state;
      byte_ready_o = 1'b0;
      case (state)
         HDR: begin
            byte_ready_o = 1'b1;
            if (word_full) begin
               if (word == 32'd0)
                  state_next = DONE;
               else if ({1'b0, word} > CAPACITY)
                  state_next = ERR;
               else
                  state_next = DATA;
            end
         end
         DATA: begin
            byte_ready_o = 1'b1;
            if (word_full)
               state_next = WRITE;
         end
         WRITE: begin
            if (33'(count_inc) == {1'b0, len})
               state_next = DONE;
            else
               state_next = DATA;
         end
         DONE:    state_next = DONE;
         ERR:     state_next = ERR;
         default: state_next = HDR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= HDR;
      else
         state <= state_next;
   end

   // Status outputs are registered from the next state so they line up
   // with the first cycle spent in WRITE, DONE or ERR.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt       <= '0;
         shift          <= '0;
         len            <= '0;
         we_o           <= 1'b0;
         waddr_o        <= '0;
         wdata_o        <= '0;
         cpu_rst_o      <= 1'b1;
         done_o         <= 1'b0;
         err_o          <= 1'b0;
         words_loaded_o <= '0;
      end else begin
         if (accept) begin
            shift    <= word[23:0];
            byte_cnt <= byte_cnt + 2'd1;
         end
         if (state == HDR && word_full)
            len <= word;
         if (state == DATA && word_full) begin
            wdata_o <= word;
            waddr_o <= words_loaded_o[ADDR_W-1:0];
         end
         if (state == WRITE)
            words_loaded_o <= count_inc;
         we_o      <= (state_next == WRITE);
         done_o    <= (state_next == DONE);
         err_o     <= (state_next == ERR);
         cpu_rst_o <= (state_next != DONE);
      end
   end

endmodule
